// File: rtl/hdma_controller.sv
// CGB VRAM DMA engine: general-purpose and HBlank block copies into VRAM.
// Bus master toward the memory arbiter; reports progress through FF55.
module hdma_controller #(
  parameter int          BLOCK_BYTES = 16,
  parameter logic [15:0] VRAM_BASE   = 16'h8000
) (
  input  logic        clk4_2,
  input  logic        reset_n,
  input  logic        DMA_start,
  input  logic [7:0]  HDMA1,
  input  logic [7:0]  HDMA2,
  input  logic [7:0]  HDMA3,
  input  logic [7:0]  HDMA4,
  input  logic [7:0]  HDMA5,
  input  logic [1:0]  STAT_mode,
  input  logic        lcd_on,
  input  logic [7:0]  dma_rdata,
  output logic [15:0] dma_addr,
  output logic        dma_read,
  output logic        dma_write,
  output logic [7:0]  dma_wdata,
  output logic        dma_active,
  output logic        GDMA_finished,
  output logic [7:0]  hdma_status
);

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, HB_WAIT, HB_ARM
  } state_t;

  localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);

  state_t      state;
  logic [15:0] src;
  logic [12:0] dst_off;
  logic [7:0]  blocks_left;
  logic        mode;
  logic [3:0]  byte_cnt;

  logic cancel;
  logic in_hblank;
  logic unused_bits;

  assign cancel      = DMA_start && !HDMA5[7];
  assign in_hblank   = (STAT_mode == 2'b00) && lcd_on;
  assign unused_bits = ^{HDMA2[3:0], HDMA3[7:5], HDMA4[3:0]};

  always_ff @(posedge clk4_2 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      src           <= '0;
      dst_off       <= '0;
      blocks_left   <= '0;
      mode          <= 1'b0;
      byte_cnt      <= '0;
      dma_addr      <= '0;
      dma_read      <= 1'b0;
      dma_write     <= 1'b0;
      dma_wdata     <= '0;
      dma_active    <= 1'b0;
      GDMA_finished <= 1'b0;
      hdma_status   <= 8'hFF;
    end else begin
      dma_read      <= 1'b0;
      dma_write     <= 1'b0;
      dma_active    <= 1'b0;
      GDMA_finished <= 1'b0;
      unique case (state)
        IDLE: begin
          if (DMA_start) begin
            src         <= {HDMA1, HDMA2[7:4], 4'h0};
            dst_off     <= {HDMA3[4:0], HDMA4[7:4], 4'h0};
            blocks_left <= {1'b0, HDMA5[6:0]} + 8'd1;
            mode        <= HDMA5[7];
            byte_cnt    <= '0;
            hdma_status <= {1'b0, HDMA5[6:0]};
            if (HDMA5[7]) begin
              state <= HB_ARM;
            end else begin
              state      <= READ;
              dma_read   <= 1'b1;
              dma_active <= 1'b1;
              dma_addr   <= {HDMA1, HDMA2[7:4], 4'h0};
            end
          end
        end
        HB_ARM: begin
          if (cancel) begin
            state       <= IDLE;
            hdma_status <= {1'b1, blocks_left[6:0] - 7'd1};
          end else if (!in_hblank) begin
            state <= HB_WAIT;
          end
        end
        HB_WAIT: begin
          if (cancel) begin
            state       <= IDLE;
            hdma_status <= {1'b1, blocks_left[6:0] - 7'd1};
          end else if (in_hblank) begin
            state      <= READ;
            dma_read   <= 1'b1;
            dma_active <= 1'b1;
            dma_addr   <= src;
          end
        end
        READ: begin
          state      <= WRITE;
          dma_wdata  <= dma_rdata;
          dma_write  <= 1'b1;
          dma_active <= 1'b1;
          dma_addr   <= VRAM_BASE | {3'b000, dst_off};
        end
        WRITE: begin
          src      <= src + 16'd1;
          dst_off  <= dst_off + 13'd1;
          byte_cnt <= byte_cnt + 4'd1;
          if (byte_cnt == LAST) begin
            blocks_left <= blocks_left - 8'd1;
            if (blocks_left == 8'd1) begin
              state         <= IDLE;
              GDMA_finished <= 1'b1;
              hdma_status   <= 8'hFF;
            end else begin
              hdma_status <= {1'b0, blocks_left[6:0] - 7'd2};
              if (mode) begin
                state <= HB_ARM;
              end else begin
                state      <= READ;
                dma_read   <= 1'b1;
                dma_active <= 1'b1;
                dma_addr   <= src + 16'd1;
              end
            end
          end else begin
            state      <= READ;
            dma_read   <= 1'b1;
            dma_active <= 1'b1;
            dma_addr   <= src + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdma_controller.sv
// Bench for hdma_controller: random source data, per-scenario tasks,
// expected write streams built from the register values.
module tb_hdma_controller;

  logic        clk4_2 = 1'b0;
  logic        reset_n = 1'b0;
  logic        DMA_start = 1'b0;
  logic [7:0]  HDMA1 = '0, HDMA2 = '0, HDMA3 = '0, HDMA4 = '0, HDMA5 = '0;
  logic [1:0]  STAT_mode = 2'd3;
  logic        lcd_on = 1'b1;
  logic [7:0]  dma_rdata;
  logic [15:0] dma_addr;
  logic        dma_read, dma_write, dma_active, GDMA_finished;
  logic [7:0]  dma_wdata, hdma_status;

  hdma_controller dut (
    .clk4_2(clk4_2), .reset_n(reset_n), .DMA_start(DMA_start),
    .HDMA1(HDMA1), .HDMA2(HDMA2), .HDMA3(HDMA3), .HDMA4(HDMA4),
    .HDMA5(HDMA5), .STAT_mode(STAT_mode), .lcd_on(lcd_on),
    .dma_rdata(dma_rdata), .dma_addr(dma_addr), .dma_read(dma_read),
    .dma_write(dma_write), .dma_wdata(dma_wdata),
    .dma_active(dma_active), .GDMA_finished(GDMA_finished),
    .hdma_status(hdma_status)
  );

  always #5 clk4_2 = ~clk4_2;

  logic [7:0] mem [0:65535];
  assign dma_rdata = mem[dma_addr];

  int n_cmp = 0;
  int n_err = 0;
  int ncyc = 0, act_cnt = 0, fin_cnt = 0, fin_at = 0, t0 = 0;
  logic [15:0] wa[$], ra[$], ea[$];
  logic [7:0]  wd[$], ed[$];

  always @(negedge clk4_2) begin
    ncyc++;
    if (dma_active) act_cnt++;
    if (dma_read) ra.push_back(dma_addr);
    if (dma_write) begin
      wa.push_back(dma_addr);
      wd.push_back(dma_wdata);
    end
    if (GDMA_finished) begin
      if (fin_cnt == 0) fin_at = ncyc;
      fin_cnt++;
    end
  end

  task clear_log;
    wa.delete(); wd.delete(); ra.delete();
    act_cnt = 0; fin_cnt = 0; fin_at = 0;
  endtask

  task start(input logic [7:0] h1, h2, h3, h4, h5);
    @(posedge clk4_2); #1;
    HDMA1 = h1; HDMA2 = h2; HDMA3 = h3; HDMA4 = h4; HDMA5 = h5;
    DMA_start = 1'b1;
    @(posedge clk4_2); #1;
    DMA_start = 1'b0;
    t0 = ncyc;
  endtask

  // Expected write stream: every byte of every block, in order.
  task model(input logic [7:0] h1, h2, h3, h4, h5);
    logic [15:0] s;
    logic [12:0] o, d;
    int n;
    ea.delete(); ed.delete();
    s = {h1, h2[7:4], 4'h0};
    o = {h3[4:0], h4[7:4], 4'h0};
    n = (int'(h5[6:0]) + 1) * 16;
    for (int k = 0; k < n; k++) begin
      d = o + 13'(k);
      ea.push_back({3'b100, d});
      ed.push_back(mem[s + 16'(k)]);
    end
  endtask

  function automatic int log_bad(input int n);
    int b = 0;
    for (int k = 0; k < n; k++)
      if (k >= wa.size() || k >= ea.size() || wa[k] !== ea[k] || wd[k] !== ed[k])
        b++;
    return b;
  endfunction

  task wait_fin(input int budget);
    for (int i = 0; i < budget && fin_cnt == 0; i++) @(negedge clk4_2);
    n_cmp++;
    if (fin_cnt == 0) begin
      n_err++;
      $display("FAIL fin_timeout: no GDMA_finished within %0d cycles", budget);
    end
    repeat (4) @(negedge clk4_2);
  endtask

  task test_reset;
    #12;
    n_cmp++;
    if ({dma_read, dma_write, dma_active, GDMA_finished} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b required 0000",
               {dma_read, dma_write, dma_active, GDMA_finished});
    end
    n_cmp++;
    if (dma_addr !== 16'h0 || dma_wdata !== 8'h0) begin
      n_err++;
      $display("FAIL reset_bus: addr %h wdata %h required 0000 00", dma_addr, dma_wdata);
    end
    n_cmp++;
    if (hdma_status !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_status: got %h required FF", hdma_status);
    end
    @(negedge clk4_2);
    reset_n = 1'b1;
    repeat (3) @(negedge clk4_2);
    n_cmp++;
    if (dma_active !== 1'b0 || hdma_status !== 8'hFF) begin
      n_err++;
      $display("FAIL idle_after_reset: active %b status %h required 0 FF",
               dma_active, hdma_status);
    end
  endtask

  task test_gdma_one;
    for (int i = 0; i < 16; i++) mem[16'hC000 + i] = 8'(i);
    clear_log();
    model(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);
    start(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_fin(100);
    n_cmp++;
    if (wa.size() != 16 || log_bad(16) != 0) begin
      n_err++;
      $display("FAIL gdma1_log: %0d writes %0d bad required 16 writes 8000.. data 00..",
               wa.size(), log_bad(16));
    end
    n_cmp++;
    if (act_cnt != 32) begin
      n_err++;
      $display("FAIL gdma1_active: got %0d cycles required 32", act_cnt);
    end
    n_cmp++;
    if (fin_cnt != 1 || fin_at - t0 != 33) begin
      n_err++;
      $display("FAIL gdma1_finish: %0d pulses at cycle %0d required 1 at 33",
               fin_cnt, fin_at - t0);
    end
    n_cmp++;
    if (hdma_status !== 8'hFF) begin
      n_err++;
      $display("FAIL gdma1_status: got %h required FF", hdma_status);
    end
  endtask

  task test_wrap;
    logic [7:0] h1;
    h1 = 8'($urandom);
    clear_log();
    model(h1, 8'h3F, 8'hFF, 8'hFF, 8'h01);
    start(h1, 8'h3F, 8'hFF, 8'hFF, 8'h01);
    wait_fin(150);
    n_cmp++;
    if (ra.size() == 0 || ra[0] !== {h1, 8'h30}) begin
      n_err++;
      $display("FAIL wrap_src: got %h required %h", ra.size() ? ra[0] : 16'hxxxx,
               {h1, 8'h30});
    end
    n_cmp++;
    if (wa.size() < 17 || wa[0] !== 16'h9FF0 || wa[16] !== 16'h8000) begin
      n_err++;
      $display("FAIL wrap_dst: %0d writes first %h second-block %h required 9FF0 8000",
               wa.size(), wa.size() ? wa[0] : 16'hxxxx,
               wa.size() > 16 ? wa[16] : 16'hxxxx);
    end
    n_cmp++;
    if (wa.size() != 32 || log_bad(32) != 0) begin
      n_err++;
      $display("FAIL wrap_log: %0d writes %0d bad required 32", wa.size(), log_bad(32));
    end
  endtask

  task test_random_gdma;
    logic [7:0] h1, h2, h3, h4, h5;
    int n;
    for (int r = 0; r < 4; r++) begin
      h1 = 8'($urandom); h2 = 8'($urandom);
      h3 = 8'($urandom); h4 = 8'($urandom);
      h5 = 8'($urandom_range(0, 3));
      n = int'(h5) + 1;
      clear_log();
      model(h1, h2, h3, h4, h5);
      start(h1, h2, h3, h4, h5);
      wait_fin(32 * n + 40);
      n_cmp++;
      if (wa.size() != 16 * n || log_bad(16 * n) != 0) begin
        n_err++;
        $display("FAIL rand_log[%0d]: %0d writes %0d bad required %0d",
                 r, wa.size(), log_bad(16 * n), 16 * n);
      end
      n_cmp++;
      if (act_cnt != 32 * n || fin_at - t0 != 32 * n + 1 || fin_cnt != 1) begin
        n_err++;
        $display("FAIL rand_timing[%0d]: active %0d fin %0dx@%0d required %0d 1x@%0d",
                 r, act_cnt, fin_cnt, fin_at - t0, 32 * n, 32 * n + 1);
      end
    end
  endtask

  task test_hblank;
    logic [7:0] h1, h2, h3, h4;
    h1 = 8'($urandom); h2 = 8'($urandom);
    h3 = 8'($urandom); h4 = 8'($urandom);
    STAT_mode = 2'd3;
    clear_log();
    model(h1, h2, h3, h4, 8'h81);
    start(h1, h2, h3, h4, 8'h81);
    repeat (20) @(negedge clk4_2);
    n_cmp++;
    if (wa.size() != 0 || act_cnt != 0 || hdma_status !== 8'h01) begin
      n_err++;
      $display("FAIL hb_wait: %0d writes active %0d status %h required 0 0 01",
               wa.size(), act_cnt, hdma_status);
    end
    STAT_mode = 2'd0;
    repeat (60) @(negedge clk4_2);
    n_cmp++;
    if (wa.size() != 16 || fin_cnt != 0 || hdma_status !== 8'h00) begin
      n_err++;
      $display("FAIL hb_first: %0d writes fin %0d status %h required 16 0 00",
               wa.size(), fin_cnt, hdma_status);
    end
    STAT_mode = 2'd3;
    repeat (10) @(negedge clk4_2);
    STAT_mode = 2'd0;
    wait_fin(80);
    n_cmp++;
    if (wa.size() != 32 || log_bad(32) != 0 || act_cnt != 64) begin
      n_err++;
      $display("FAIL hb_log: %0d writes %0d bad active %0d required 32 0 64",
               wa.size(), log_bad(32), act_cnt);
    end
    n_cmp++;
    if (fin_cnt != 1 || hdma_status !== 8'hFF) begin
      n_err++;
      $display("FAIL hb_done: fin %0d status %h required 1 FF", fin_cnt, hdma_status);
    end
  endtask

  task test_cancel;
    logic [7:0] h1, h2, h3, h4;
    h1 = 8'($urandom); h2 = 8'($urandom);
    h3 = 8'($urandom); h4 = 8'($urandom);
    STAT_mode = 2'd3;
    clear_log();
    model(h1, h2, h3, h4, 8'h83);
    start(h1, h2, h3, h4, 8'h83);
    repeat (5) @(negedge clk4_2);
    lcd_on = 1'b0;
    STAT_mode = 2'd0;
    repeat (30) @(negedge clk4_2);
    n_cmp++;
    if (wa.size() != 0) begin
      n_err++;
      $display("FAIL lcd_off: got %0d writes required 0", wa.size());
    end
    lcd_on = 1'b1;
    repeat (60) @(negedge clk4_2);
    n_cmp++;
    if (wa.size() != 16 || log_bad(16) != 0 || hdma_status !== 8'h02) begin
      n_err++;
      $display("FAIL cancel_first: %0d writes %0d bad status %h required 16 0 02",
               wa.size(), log_bad(16), hdma_status);
    end
    STAT_mode = 2'd3;
    repeat (3) @(negedge clk4_2);
    start(h1, h2, h3, h4, 8'h00);
    STAT_mode = 2'd0;
    repeat (60) @(negedge clk4_2);
    n_cmp++;
    if (wa.size() != 16 || fin_cnt != 0 || act_cnt != 32) begin
      n_err++;
      $display("FAIL cancel_stop: %0d writes fin %0d active %0d required 16 0 32",
               wa.size(), fin_cnt, act_cnt);
    end
    n_cmp++;
    if (hdma_status !== 8'h82) begin
      n_err++;
      $display("FAIL cancel_status: got %h required 82", hdma_status);
    end
  endtask

  task test_max;
    logic [7:0] h2;
    logic [15:0] s;
    h2 = 8'($urandom);
    s = {8'hFF, h2[7:4], 4'h0};
    clear_log();
    model(8'hFF, h2, 8'h00, 8'h00, 8'h7F);
    start(8'hFF, h2, 8'h00, 8'h00, 8'h7F);
    wait_fin(4200);
    n_cmp++;
    if (wa.size() != 2048 || log_bad(2048) != 0) begin
      n_err++;
      $display("FAIL max_log: %0d writes %0d bad required 2048", wa.size(), log_bad(2048));
    end
    n_cmp++;
    if (act_cnt != 4096 || fin_at - t0 != 4097) begin
      n_err++;
      $display("FAIL max_timing: active %0d fin@%0d required 4096 4097",
               act_cnt, fin_at - t0);
    end
    n_cmp++;
    if (ra.size() != 2048 || ra[2047] !== s + 16'd2047) begin
      n_err++;
      $display("FAIL max_src_wrap: %0d reads last %h required 2048 %h", ra.size(),
               ra.size() ? ra[ra.size() - 1] : 16'hxxxx, s + 16'd2047);
    end
  endtask

  task test_reset_mid;
    logic [7:0] h1, h2, h3, h4;
    bit hit;
    h1 = 8'($urandom); h2 = 8'($urandom);
    h3 = 8'($urandom); h4 = 8'($urandom);
    clear_log();
    start(h1, h2, h3, h4, 8'h00);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk4_2); #3;
      if (wa.size() == 5 && dma_write) hit = 1'b1;
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL rst_mid_reach: sixth write not seen, %0d writes", wa.size());
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (dma_write !== 1'b0 || dma_active !== 1'b0 || dma_read !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async: write %b active %b read %b required 0 0 0",
               dma_write, dma_active, dma_read);
    end
    n_cmp++;
    if (hdma_status !== 8'hFF) begin
      n_err++;
      $display("FAIL rst_mid_status: got %h required FF", hdma_status);
    end
    #10;
    reset_n = 1'b1;
    h1 = 8'($urandom); h3 = 8'($urandom);
    clear_log();
    model(h1, h2, h3, h4, 8'h00);
    start(h1, h2, h3, h4, 8'h00);
    wait_fin(80);
    n_cmp++;
    if (wa.size() != 16 || log_bad(16) != 0 || fin_cnt != 1) begin
      n_err++;
      $display("FAIL rst_restart: %0d writes %0d bad fin %0d required 16 0 1",
               wa.size(), log_bad(16), fin_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_gdma_one();
    test_wrap();
    test_random_gdma();
    test_hblank();
    test_cancel();
    test_max();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
